// File: rtl/zint_mc.sv
// Multi-source Z80 IM2 interrupt controller: latches requests, resolves fixed
// priority on the acknowledge edge and returns the winning source's vector.
module zint_mc #(
    parameter int         NUM_SRC   = 3,
    parameter logic [7:0] VEC_BASE  = 8'hFF,
    parameter int         VEC_STEP  = 2,
    parameter int         PULSE_LEN = 32,
    parameter logic [7:0] TMO_MASK  = 8'h01,
    parameter logic [7:0] DROP_MASK = 8'h03
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               zpos,
    input  logic [NUM_SRC-1:0] int_start,
    input  logic [NUM_SRC-1:0] intmask,
    input  logic               vdos,
    input  logic               intack,
    input  logic [NUM_SRC-1:0] clr,
    output logic [NUM_SRC-1:0] pend,
    output logic [7:0]         im2vect,
    output logic               int_n
);

    localparam int CW = $clog2(PULSE_LEN) + 1;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] fin;
    logic [NUM_SRC-1:0] win_oh;
    logic [7:0]         win_vec;
    logic [7:0]         im2vect_q;
    logic               intack_q, intack_r_q;
    logic               ack_s;

    // intack comes straight from the CPU bus, so it is sampled once before edge detection
    assign ack_s = intack_q & ~intack_r_q;

    always_comb begin
        win_oh  = '0;
        win_vec = VEC_BASE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_vec    = VEC_BASE - 8'(VEC_STEP * i);
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        accept = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            accept[i] = intmask[i] & int_start[i] & ~(DROP_MASK[i] & vdos);
            if (!intmask[i])
                pend_d[i] = 1'b0;
            else if (accept[i])
                pend_d[i] = 1'b1;
            else if (ack_s && win_oh[i])
                pend_d[i] = 1'b0;
            else if (clr[i])
                pend_d[i] = 1'b0;
            else if (TMO_MASK[i] && fin[i])
                pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pend_q     <= '0;
            im2vect_q  <= VEC_BASE;
            intack_q   <= 1'b0;
            intack_r_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            intack_q   <= intack;
            intack_r_q <= intack_q;
            if (ack_s && (|pend_q))
                im2vect_q <= win_vec;
        end
    end

    // Pulse-window counters sit idle at PULSE_LEN and only exist for expiring sources
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        if (TMO_MASK[g]) begin : g_tmo
            logic [CW-1:0] cnt_q;
            assign fin[g] = (cnt_q == CW'(PULSE_LEN));
            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n)
                    cnt_q <= CW'(PULSE_LEN);
                else if (accept[g])
                    cnt_q <= '0;
                else if (zpos && !fin[g] && !vdos)
                    cnt_q <= cnt_q + CW'(1);
            end
        end else begin : g_notmo
            assign fin[g] = 1'b0;
        end
    end

    assign pend    = pend_q;
    assign im2vect = im2vect_q;
    assign int_n   = ~(|pend_q) | vdos;

endmodule

// File: tb/tb_zint_mc.sv
// Directed bench for zint_mc: default three-source instance plus an eight-source one.
module tb_zint_mc;

    logic       clk = 1'b0;
    logic       res_n, zpos, vdos, intack;
    logic [2:0] intStart, intMask, clrV, pendV;
    logic [7:0] vect;
    logic       intN;

    logic       res8N, intack8;
    logic [7:0] intStart8, pend8, vect8;
    logic       intN8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zint_mc dut (
        .clk(clk), .res_n(res_n), .zpos(zpos), .int_start(intStart),
        .intmask(intMask), .vdos(vdos), .intack(intack), .clr(clrV),
        .pend(pendV), .im2vect(vect), .int_n(intN)
    );

    zint_mc #(.NUM_SRC(8), .VEC_STEP(2)) dut8 (
        .clk(clk), .res_n(res8N), .zpos(1'b0), .int_start(intStart8),
        .intmask(8'hFF), .vdos(1'b0), .intack(intack8), .clr(8'h00),
        .pend(pend8), .im2vect(vect8), .int_n(intN8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stepClk(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart(input logic [2:0] s);
        intStart = s;
        stepClk();
        intStart = '0;
    endtask

    task automatic pulseAck();
        intack = 1'b1;
        stepClk();
        intack = 1'b0;
        stepClk();
    endtask

    task automatic zTick();
        zpos = 1'b1;
        stepClk();
        zpos = 1'b0;
        stepClk(3);
    endtask

    initial begin
        res_n = 1'b0; zpos = 1'b0; vdos = 1'b0; intack = 1'b0;
        intStart = '0; intMask = 3'b111; clrV = '0;
        res8N = 1'b0; intack8 = 1'b0; intStart8 = '0;
        stepClk(2);
        checkOutput("rst_pend", 32'(pendV), 32'h0);
        checkOutput("rst_vect", 32'(vect), 32'hFF);
        checkOutput("rst_intn", 32'(intN), 32'h1);
        res_n = 1'b1; res8N = 1'b1;
        stepClk();

        // priority between two simultaneous requests
        pulseStart(3'b110);
        checkOutput("prio_pend0", 32'(pendV), 32'h6);
        checkOutput("prio_intn0", 32'(intN), 32'h0);
        pulseAck();
        checkOutput("prio_vect1", 32'(vect), 32'hFD);
        checkOutput("prio_pend1", 32'(pendV), 32'h4);
        checkOutput("prio_intn1", 32'(intN), 32'h0);
        pulseAck();
        checkOutput("prio_vect2", 32'(vect), 32'hFB);
        checkOutput("prio_pend2", 32'(pendV), 32'h0);
        checkOutput("prio_intn2", 32'(intN), 32'h1);

        // spurious acknowledge keeps the last vector
        pulseAck();
        checkOutput("spur_vect", 32'(vect), 32'hFB);
        checkOutput("spur_intn", 32'(intN), 32'h1);

        // held acknowledge counts once
        pulseStart(3'b011);
        intack = 1'b1;
        stepClk(10);
        checkOutput("held_pend", 32'(pendV), 32'h2);
        checkOutput("held_vect", 32'(vect), 32'hFF);
        intack = 1'b0;
        stepClk();

        // write-1-to-clear
        clrV = 3'b010;
        stepClk();
        clrV = '0;
        checkOutput("clr_pend", 32'(pendV), 32'h0);

        // VDOS drop / hold policy
        vdos = 1'b1;
        pulseStart(3'b111);
        checkOutput("vdos_pend", 32'(pendV), 32'h4);
        checkOutput("vdos_intn", 32'(intN), 32'h1);
        vdos = 1'b0;
        #1;
        checkOutput("vdos_rel_intn", 32'(intN), 32'h0);
        pulseAck();
        checkOutput("vdos_vect", 32'(vect), 32'hFB);
        checkOutput("vdos_pend2", 32'(pendV), 32'h0);

        // start and acknowledge of the same source collide: start wins
        pulseStart(3'b010);
        intack = 1'b1;
        stepClk();
        intack = 1'b0;
        intStart = 3'b010;
        stepClk();
        intStart = '0;
        checkOutput("coll_pend", 32'(pendV), 32'h2);
        checkOutput("coll_vect", 32'(vect), 32'hFD);
        clrV = 3'b010;
        stepClk();
        clrV = '0;

        // mask clears and re-enable does not restore
        pulseStart(3'b100);
        intMask = 3'b011;
        stepClk();
        checkOutput("mask_pend", 32'(pendV), 32'h0);
        intMask = 3'b111;
        stepClk();
        checkOutput("unmask_pend", 32'(pendV), 32'h0);

        // auto-expiry after PULSE_LEN zpos ticks
        pulseStart(3'b001);
        for (int t = 0; t < 31; t++) zTick();
        checkOutput("tmo_31", 32'(pendV), 32'h1);
        zTick();
        checkOutput("tmo_32", 32'(pendV), 32'h0);

        // VDOS freezes the window
        pulseStart(3'b001);
        for (int t = 0; t < 10; t++) zTick();
        vdos = 1'b1;
        for (int t = 0; t < 5; t++) zTick();
        checkOutput("frz_intn", 32'(intN), 32'h1);
        vdos = 1'b0;
        for (int t = 0; t < 21; t++) zTick();
        checkOutput("frz_31", 32'(pendV), 32'h1);
        zTick();
        checkOutput("frz_32", 32'(pendV), 32'h0);

        // eight sources, full priority walk
        intStart8 = 8'hFF;
        stepClk();
        intStart8 = '0;
        checkOutput("s8_pend", 32'(pend8), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] expV;
            expV = 8'hFF - 8'(2 * i);
            intack8 = 1'b1;
            stepClk();
            intack8 = 1'b0;
            stepClk();
            checkOutput($sformatf("s8_vect%0d", i), 32'(vect8), 32'(expV));
        end
        checkOutput("s8_intn", 32'(intN8), 32'h1);

        // asynchronous reset mid-sequence
        intStart8 = 8'hFF;
        stepClk();
        intStart8 = '0;
        for (int i = 0; i < 3; i++) begin
            intack8 = 1'b1;
            stepClk();
            intack8 = 1'b0;
            stepClk();
        end
        checkOutput("s8_mid_vect", 32'(vect8), 32'hFB);
        #2;
        res8N = 1'b0;
        #1;
        checkOutput("s8_rst_pend", 32'(pend8), 32'h0);
        checkOutput("s8_rst_vect", 32'(vect8), 32'hFF);
        checkOutput("s8_rst_intn", 32'(intN8), 32'h1);
        stepClk();
        res8N = 1'b1;
        stepClk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
